controle_multiciclo: RTL and testbench

Multi-cycle control FSM that sequences the processor datapath: register bank, operand muxes and ULA. Each instruction is stepped through FETCH, DECODE, EXEC, MEM and WB. The block drives every datapath control strobe and handshakes with a single shared instruction/data memory port. It sits beside the datapath top level and replaces the free-running control inputs with one sequenced instruction stream.

---
 rtl/controle_multiciclo.sv | 205 ++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port
// and drives all datapath strobes from the state register and captured IR.
module controle_multiciclo #(
    parameter int LARGURA_ESTADO = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               instrucao,
    input  logic                      mem_pronta,
    input  logic                      Zero,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic                      ir_load,
    output logic                      pc_write,
    output logic [1:0]                pc_src,
    output logic [3:0]                ALUOp,
    output logic                      ALUSrc,
    output logic                      ULAData,
    output logic                      SumZero,
    output logic                      RegWrite,
    output logic                      NOP,
    output logic                      StackOP,
    output logic                      JAL,
    output logic                      mem_to_reg,
    output logic                      erro,
    output logic [LARGURA_ESTADO-1:0] estado
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERRO   = 3'd7
    } estado_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_PUSH = 6'h38;
    localparam logic [5:0] OP_POP  = 6'h39;

    estado_t     estado_q, estado_d;
    logic [31:0] ir_q, ir_d;
    logic        erro_q, erro_d;

    logic [5:0] opcode, funct;
    logic       funct_ok, op_ok, eh_nop;
    logic [3:0] alu_r;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign eh_nop = (ir_q == 32'h0);

    always_comb begin
        funct_ok = 1'b1;
        alu_r    = 4'b0010;
        unique case (funct)
            6'h20:   alu_r = 4'b0010;
            6'h22:   alu_r = 4'b0110;
            6'h24:   alu_r = 4'b0000;
            6'h25:   alu_r = 4'b0001;
            6'h2A:   alu_r = 4'b0111;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        op_ok = 1'b0;
        case (opcode)
            OP_R:                                   op_ok = funct_ok;
            OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW,
            OP_SW, OP_PUSH, OP_POP:                 op_ok = 1'b1;
            default:                                op_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= S_FETCH;
            ir_q     <= 32'h0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            ir_q     <= ir_d;
            erro_q   <= erro_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        ir_d     = ir_q;
        erro_d   = erro_q;
        case (estado_q)
            S_FETCH: if (mem_pronta) begin
                ir_d     = instrucao;
                estado_d = S_DECODE;
            end
            S_DECODE: begin
                if (eh_nop || opcode == OP_J || opcode == OP_JAL) estado_d = S_FETCH;
                else if (!op_ok)                                  estado_d = S_ERRO;
                else                                              estado_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_R, OP_ADDI:                 estado_d = S_WB;
                    OP_LW, OP_SW, OP_PUSH, OP_POP: estado_d = S_MEM;
                    default:                       estado_d = S_FETCH;
                endcase
            end
            S_MEM: if (mem_pronta) begin
                estado_d = (opcode == OP_SW || opcode == OP_PUSH) ? S_FETCH : S_WB;
            end
            S_WB:    estado_d = S_FETCH;
            S_ERRO:  estado_d = S_ERRO;
            default: estado_d = S_FETCH;
        endcase
        if (estado_d == S_ERRO) erro_d = 1'b1;
    end

    // Output logic; reset overrides everything so nothing leaks out on an aborted instruction
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ALUOp      = 4'b0000;
        ALUSrc     = 1'b0;
        ULAData    = 1'b0;
        SumZero    = 1'b0;
        RegWrite   = 1'b0;
        NOP        = 1'b0;
        StackOP    = 1'b0;
        JAL        = 1'b0;
        mem_to_reg = 1'b0;
        if (!reset) begin
            case (estado_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_pronta) begin
                        ir_load  = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (eh_nop) NOP = 1'b1;
                    else if (opcode == OP_J) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                    end else if (opcode == OP_JAL) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        RegWrite = 1'b1;
                        JAL      = 1'b1;
                    end
                end
                S_EXEC: begin
                    ULAData = 1'b1;
                    case (opcode)
                        OP_R:    ALUOp = alu_r;
                        OP_ADDI, OP_LW, OP_SW: begin
                            ALUSrc = 1'b1;
                            ALUOp  = 4'b0010;
                        end
                        // Stack pointer adjust happens here, so the strobe is one cycle regardless of memory waits
                        OP_PUSH, OP_POP: begin
                            StackOP = 1'b1;
                            ALUSrc  = 1'b1;
                            ALUOp   = 4'b0010;
                        end
                        OP_BEQ: begin
                            ALUOp = 4'b0110;
                            if (Zero) begin
                                pc_write = 1'b1;
                                pc_src   = 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (opcode == OP_SW || opcode == OP_PUSH);
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    mem_to_reg = (opcode == OP_LW || opcode == OP_POP);
                end
                default: ;
            endcase
        end
    end

    assign erro   = erro_q & ~reset;
    assign estado = reset ? '0 : LARGURA_ESTADO'(estado_q);

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: inputs change on the falling edge, outputs checked 1 time unit later.
module tb_controle_multiciclo;

    logic        clock = 1'b0;
    logic        reset, mem_pronta, Zero;
    logic [31:0] instrucao;
    logic        mem_req, mem_we, ir_load, pc_write, ALUSrc, ULAData, SumZero;
    logic        RegWrite, NOP, StackOP, JAL, mem_to_reg, erro;
    logic [1:0]  pc_src;
    logic [3:0]  ALUOp;
    logic [2:0]  estado;

    int tests = 0;
    int fails = 0;

    controle_multiciclo #(.LARGURA_ESTADO(3)) dut (
        .clock(clock), .reset(reset), .instrucao(instrucao), .mem_pronta(mem_pronta), .Zero(Zero),
        .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
        .ALUOp(ALUOp), .ALUSrc(ALUSrc), .ULAData(ULAData), .SumZero(SumZero), .RegWrite(RegWrite),
        .NOP(NOP), .StackOP(StackOP), .JAL(JAL), .mem_to_reg(mem_to_reg), .erro(erro), .estado(estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic p, input logic z, input logic [31:0] ins);
        @(negedge clock);
        reset = r; mem_pronta = p; Zero = z; instrucao = ins;
        #1;
    endtask

    // Strobe bundle {ir_load,pc_write,RegWrite,NOP,StackOP,JAL,mem_we,mem_to_reg}
    function automatic logic [7:0] strobes();
        return {ir_load, pc_write, RegWrite, NOP, StackOP, JAL, mem_we, mem_to_reg};
    endfunction

    initial begin
        reset = 1'b1; mem_pronta = 1'b0; Zero = 1'b0; instrucao = 32'h0;

        // Reset held 3 cycles: everything zero
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 32'h0);
            chk("rst_estado", estado, 0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_strobes", strobes(), 0);
            chk("rst_erro", erro, 0);
        end

        // add $8,$9,$10 with zero-wait memory: 0,1,2,4,0
        step(0, 1, 0, 32'h012A4020);
        chk("add_f_estado", estado, 0);
        chk("add_f_req", {mem_req, mem_we}, 2'b10);
        chk("add_f_str", {ir_load, pc_write, pc_src}, 4'b1100);
        step(0, 1, 0, 32'h012A4020);
        chk("add_d_estado", estado, 1);
        chk("add_d_str", strobes(), 0);
        step(0, 1, 0, 32'h012A4020);
        chk("add_e_estado", estado, 2);
        chk("add_e_alu", {ALUOp, ALUSrc, ULAData}, 6'b0010_0_1);
        chk("add_e_regw", RegWrite, 0);
        step(0, 1, 0, 32'h012A4020);
        chk("add_wb_estado", estado, 4);
        chk("add_wb_str", strobes(), 8'b0010_0000);
        chk("add_wb_sumzero", SumZero, 0);

        // lw with 2 wait cycles in MEM: 7 cycles total
        step(0, 1, 0, 32'h8D090004);
        chk("lw_f_estado", estado, 0);
        chk("lw_f_irload", ir_load, 1);
        step(0, 0, 0, 32'h8D090004);
        chk("lw_d_estado", estado, 1);
        step(0, 0, 0, 32'h8D090004);
        chk("lw_e_estado", estado, 2);
        chk("lw_e_alu", {ALUOp, ALUSrc, ULAData}, 6'b0010_1_1);
        for (int i = 0; i < 3; i++) begin
            step(0, (i == 2), 0, 32'h8D090004);
            chk("lw_m_estado", estado, 3);
            chk("lw_m_req", {mem_req, mem_we}, 2'b10);
        end
        step(0, 0, 0, 32'h8D090004);
        chk("lw_wb_estado", estado, 4);
        chk("lw_wb_str", {RegWrite, mem_to_reg}, 2'b11);
        step(0, 0, 0, 32'h8D090004);
        chk("lw_end_estado", estado, 0);

        // beq, Zero=1 in EXEC: branch pulse
        step(0, 1, 0, 32'h11280003);
        chk("beq1_f_estado", estado, 0);
        step(0, 1, 1, 32'h11280003);
        chk("beq1_d_pcw", pc_write, 0);
        step(0, 1, 1, 32'h11280003);
        chk("beq1_e_estado", estado, 2);
        chk("beq1_e_pc", {pc_write, pc_src, ALUOp, ALUSrc}, 8'b1_01_0110_0);

        // beq, Zero=0 in EXEC (Zero=1 outside EXEC must not matter)
        step(0, 1, 1, 32'h11280003);
        chk("beq1_end_estado", estado, 0);
        step(0, 1, 1, 32'h11280003);
        chk("beq0_d_estado", estado, 1);
        chk("beq0_d_pcw", pc_write, 0);
        step(0, 1, 0, 32'h11280003);
        chk("beq0_e_estado", estado, 2);
        chk("beq0_e_pc", {pc_write, pc_src}, 3'b0_00);

        // jal: combined DECODE strobe
        step(0, 1, 0, 32'h0C000010);
        chk("beq0_end_estado", estado, 0);
        step(0, 1, 0, 32'h0C000010);
        chk("jal_d_estado", estado, 1);
        chk("jal_d_str", {pc_write, pc_src, RegWrite, JAL, NOP}, 6'b1_10_11_0);

        // nop: NOP strobe in DECODE, back to FETCH
        step(0, 1, 0, 32'h00000000);
        chk("jal_end_estado", estado, 0);
        step(0, 0, 0, 32'h00000000);
        chk("nop_d_str", strobes(), 8'b0001_0000);
        step(0, 1, 0, 32'hAD090004);
        chk("nop_end_estado", estado, 0);

        // sw, reset during MEM wait
        step(0, 0, 0, 32'hAD090004);
        chk("sw_d_estado", estado, 1);
        step(0, 0, 0, 32'hAD090004);
        chk("sw_e_estado", estado, 2);
        step(0, 0, 0, 32'hAD090004);
        chk("sw_m_req", {estado, mem_req, mem_we}, 5'b011_1_1);
        step(1, 0, 0, 32'hAD090004);
        chk("sw_rst_req", {mem_req, mem_we}, 2'b00);
        chk("sw_rst_estado", estado, 0);
        step(0, 0, 0, 32'h0);
        chk("sw_after_estado", estado, 0);
        chk("sw_after_req", {mem_req, mem_we}, 2'b10);

        // illegal opcode: locks in ERRO until reset
        step(0, 1, 0, 32'hFC000000);
        step(0, 1, 0, 32'hFC000000);
        chk("ill_d_estado", estado, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 32'hFC000000);
            chk("ill_estado", estado, 7);
            chk("ill_erro", erro, 1);
            chk("ill_outs", {mem_req, strobes(), pc_src, ALUOp, ULAData}, 0);
        end
        step(1, 0, 0, 32'h0);
        chk("ill_rst_erro", erro, 0);
        step(0, 0, 0, 32'h0);
        chk("ill_post_estado", estado, 0);
        chk("ill_post_erro", erro, 0);
        chk("ill_post_req", mem_req, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
